// File: rtl/lsu_byte_master.sv
// Load/store unit master: runs one LB/LH/LW/LBU/LHU/SB/SH/SW as byte transfers on an 8-bit req/ack bus.
// Optional macro LSU_MISALIGN_TRAP_EN aborts misaligned halfword/word accesses without any bus cycle.
module lsu_byte_master #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        MemRead,
  input  logic [1:0]        MemWrite,
  input  logic [31:0]       Address,
  input  logic [31:0]       dataToMem,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic [1:0]        state_dbg
);

  // Bus handshake: bus_req rises with bus_addr/bus_we/bus_wdata already stable and holds them
  // until a posedge sees bus_ack=1; that edge completes the byte and bus_req drops for at least one cycle.

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t        state;
  logic [31:0]   wdata_q;
  logic [31:0]   asm_q;
  logic          we_q;
  logic          sext_q;
  logic [1:0]    last_q;
  logic [1:0]    idx;
  logic [TW-1:0] tcnt;

  logic          c_we;
  logic          c_none;
  logic          c_sext;
  logic [1:0]    c_last;
  logic [1:0]    nxt_idx;

  assign state_dbg = state;
  assign nxt_idx   = idx + 2'd1;

  always_comb begin
    c_we   = (MemWrite != 2'd0);
    c_none = 1'b0;
    c_sext = 1'b0;
    c_last = 2'd3;
    if (c_we) begin
      case (MemWrite)
        2'd1:    c_last = 2'd0;
        2'd2:    c_last = 2'd1;
        default: c_last = 2'd3;
      endcase
    end else begin
      case (MemRead)
        3'd0:    c_none = 1'b1;
        3'd1:    begin c_last = 2'd0; c_sext = 1'b1; end
        3'd2:    begin c_last = 2'd1; c_sext = 1'b1; end
        3'd4:    c_last = 2'd0;
        3'd5:    c_last = 2'd1;
        default: c_last = 2'd3;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic c_mis;
  assign c_mis = ((c_last == 2'd1) && Address[0]) || ((c_last == 2'd3) && (Address[1:0] != 2'd0));
`endif

  function automatic logic [31:0] put_lane(input logic [31:0] v, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = v;
    r[{i, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] last,
                                         input logic sext);
    logic [31:0] r;
    r = v;
    if (last == 2'd0)      r = sext ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
    else if (last == 2'd1) r = sext ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      data      <= 32'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 8'd0;
      wdata_q   <= 32'd0;
      asm_q     <= 32'd0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      last_q    <= 2'd0;
      idx       <= 2'd0;
      tcnt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wdata_q   <= dataToMem;
            we_q      <= c_we;
            sext_q    <= c_sext;
            last_q    <= c_last;
            idx       <= 2'd0;
            asm_q     <= 32'd0;
            tcnt      <= '0;
            bus_addr  <= Address[ADDR_W-1:0];
            bus_wdata <= dataToMem[7:0];
            bus_we    <= c_we;
            busy      <= 1'b1;
            if (c_none) begin
              state <= DONE;
              done  <= 1'b1;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            else if (c_mis) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
`endif
            else begin
              state   <= REQ;
              bus_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (idx == last_q) begin
              state <= DONE;
              done  <= 1'b1;
              if (!we_q) data <= extend(put_lane(asm_q, idx, bus_rdata), last_q, sext_q);
            end else begin
              state     <= GAP;
              asm_q     <= put_lane(asm_q, idx, bus_rdata);
              idx       <= nxt_idx;
              bus_addr  <= bus_addr + ADDR_W'(1);
              bus_wdata <= wdata_q[{nxt_idx, 3'b000} +: 8];
            end
          end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            // Abort: bytes already written stay written, the load result is cleared.
            bus_req <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
            data    <= 32'd0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        GAP: begin
          state   <= REQ;
          bus_req <= 1'b1;
          tcnt    <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
